// File: rtl/proc_pkg.sv
// Shared processor package: opcodes, instruction field positions and loader FSM states.
// Imported by both the processor controller and program_loader.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [15:0] NOOP_WORD = 16'h0000;
    localparam logic [15:0] HALT_WORD = 16'h5000;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } ld_state_t;

    // Places an opcode in the top nibble of an otherwise-zero instruction word.
    function automatic logic [15:0] opc_word(input opcode_t op);
        logic [15:0] w;
        w = 16'h0000;
        w[OPC_MSB:OPC_LSB] = op;
        return w;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Field-level instruction command channel (valid/ready) between a command source and program_loader.
interface program_loader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_ra;
    logic [3:0] cmd_rb;
    logic [3:0] cmd_rw;
    logic [7:0] cmd_daddr;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rw, cmd_daddr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rw, cmd_daddr,
        output cmd_ready
    );
endinterface

// File: rtl/program_loader_instr_encoder.sv
// Combinational encoder from instruction fields to the 16-bit word the controller decodes.
// Unknown opcodes encode as NOOP and raise illegal.
module instr_encoder
    import proc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rw,
    input  logic [7:0]  daddr,
    output logic [15:0] word,
    output logic        illegal
);

    // Field packing per opcode; unused fields are ignored.
    always_comb begin
        word    = NOOP_WORD;
        illegal = 1'b0;
        case (op)
            OP_NOOP:  word = NOOP_WORD;
            OP_STORE: word = opc_word(OP_STORE) | {4'h0, ra, daddr};
            OP_LOAD:  word = opc_word(OP_LOAD)  | {4'h0, daddr, rw};
            OP_ADD:   word = opc_word(OP_ADD)   | {4'h0, ra, rb, rw};
            OP_SUB:   word = opc_word(OP_SUB)   | {4'h0, ra, rb, rw};
            OP_HALT:  word = HALT_WORD;
            default: begin
                word    = NOOP_WORD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Encodes field-level commands into instruction memory and releases the CPU after HALT is written.
// Optional build macro PROG_CKSUM_EN adds a running 16-bit checksum output (cksum).
module program_loader
    import proc_pkg::*;
#(
    parameter int IM_AW = 7,
    parameter int IM_DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   cmd,
    output logic [IM_AW-1:0]  im_addr,
    output logic [IM_DW-1:0]  im_wdata,
    output logic              im_we,
    output logic              cpu_run,
    output logic              bad_op,
    output logic              err,
    output logic [IM_AW:0]    words
`ifdef PROG_CKSUM_EN
    ,
    output logic [15:0]       cksum
`endif
);

    ld_state_t         state_r, state_s;
    logic              cmd_ready_r;
    logic [IM_AW-1:0]  ptr_r;
    logic [IM_AW-1:0]  im_addr_r;
    logic [IM_DW-1:0]  im_wdata_r;
    logic              im_we_r, cpu_run_r, bad_op_r, err_r;
    logic [IM_AW:0]    words_r;
    logic [15:0]       enc_word_s;
    logic              enc_illegal_s;
    logic              hs_s;

    assign hs_s = cmd.cmd_valid & cmd_ready_r;

    instr_encoder u_enc (
        .op      (cmd.cmd_op),
        .ra      (cmd.cmd_ra),
        .rb      (cmd.cmd_rb),
        .rw      (cmd.cmd_rw),
        .daddr   (cmd.cmd_daddr),
        .word    (enc_word_s),
        .illegal (enc_illegal_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_r <= ST_ACCEPT;
        else        state_r <= state_s;
    end

    // Next-state logic; the HALT test uses the word latched at handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_ACCEPT: begin
                if (hs_s) state_s = ST_WRITE;
                else      state_s = ST_ACCEPT;
            end
            ST_WRITE: begin
                if (im_wdata_r == HALT_WORD) state_s = ST_DONE;
                else if (&ptr_r)             state_s = ST_ERR;
                else                         state_s = ST_ACCEPT;
            end
            ST_DONE: state_s = ST_DONE;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ACCEPT;
        endcase
    end

    // Registered outputs, write pointer and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_ready_r <= 1'b0;
            im_we_r     <= 1'b0;
            cpu_run_r   <= 1'b0;
            err_r       <= 1'b0;
            bad_op_r    <= 1'b0;
            im_addr_r   <= {IM_AW{1'b0}};
            im_wdata_r  <= {IM_DW{1'b0}};
            ptr_r       <= {IM_AW{1'b0}};
            words_r     <= {(IM_AW+1){1'b0}};
        end else begin
            cmd_ready_r <= (state_s == ST_ACCEPT);
            im_we_r     <= (state_s == ST_WRITE);
            cpu_run_r   <= (state_s == ST_DONE);
            err_r       <= (state_s == ST_ERR);
            if ((state_r == ST_ACCEPT) && hs_s) begin
                im_addr_r  <= ptr_r;
                im_wdata_r <= enc_word_s;
                bad_op_r   <= bad_op_r | enc_illegal_s;
            end
            if (state_r == ST_WRITE) begin
                ptr_r   <= ptr_r + {{(IM_AW-1){1'b0}}, 1'b1};
                words_r <= words_r + {{IM_AW{1'b0}}, 1'b1};
            end
        end
    end

`ifdef PROG_CKSUM_EN
    logic [15:0] cksum_r;

    // Running modulo-2^16 sum of every word strobed into memory.
    always_ff @(posedge clk) begin
        if (!reset)       cksum_r <= 16'h0000;
        else if (im_we_r) cksum_r <= cksum_r + im_wdata_r[15:0];
        else              cksum_r <= cksum_r;
    end

    assign cksum = cksum_r;
`endif

    assign cmd.cmd_ready = cmd_ready_r;
    assign im_addr       = im_addr_r;
    assign im_wdata      = im_wdata_r;
    assign im_we         = im_we_r;
    assign cpu_run       = cpu_run_r;
    assign bad_op        = bad_op_r;
    assign err           = err_r;
    assign words         = words_r;

endmodule
